seq_frame_det_ctrl: RTL and testbench

Frame-level controller that sequences a configurable serial pattern detector (Mealy style, e.g. 1001) over a bounded burst of input bits.
- Latches pattern and mode on `start`, accepts exactly `frame_len` bits through a valid/ready handshake, and counts matches.
- Signals completion with a one-cycle `done` pulse.
- Sits between a bit-stream source and a status/interrupt consumer.

---
 rtl/seq_frame_det_ctrl_pkg.sv | 12 +
 rtl/seq_frame_det_ctrl_if.sv | 18 +
 rtl/seq_frame_det_ctrl_core.sv | 62 ++++++
 rtl/seq_frame_det_ctrl.sv | 128 ++++++++++++
 tb/tb_seq_frame_det_ctrl.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_frame_det_ctrl_pkg.sv
// Shared types and constants for the frame-level serial pattern detector.
package seq_det_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] PAT_1001 = 4'b1001;

endpackage

// File: rtl/seq_frame_det_ctrl_if.sv
// Serial bit-stream handshake between a bit source (master) and the detector (slave).
interface seq_frame_det_ctrl_if;
    logic bit_valid;
    logic bit_in;
    logic bit_ready;

    modport master (
        output bit_valid,
        output bit_in,
        input  bit_ready
    );

    modport slave (
        input  bit_valid,
        input  bit_in,
        output bit_ready
    );
endinterface

// File: rtl/seq_frame_det_ctrl_core.sv
// Mealy pattern matcher: history shift register, fill counter, compare and
// overlap handling. Match is combinational in the cycle of the completing bit.
module seq_match_core #(
    parameter int PAT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             shift,
    input  logic             bit_in,
    input  logic [PAT_W-1:0] pattern,
    input  logic             overlap,
    output logic             match
);
    localparam int                FILL_W   = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_ARM = FILL_W'(PAT_W - 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);

    logic [PAT_W-2:0]  history_reg, history_next;
    logic [FILL_W-1:0] fill_reg, fill_next;
    logic [PAT_W-1:0]  candidate;
    logic [PAT_W-1:0]  bit_eq;

    // Newest bit sits in the LSB so the oldest arrival lines up with the pattern MSB.
    assign candidate = {history_reg, bit_in};

    generate
        for (genvar gi = 0; gi < PAT_W; gi++) begin : g_cmp
            assign bit_eq[gi] = ~(candidate[gi] ^ pattern[gi]);
        end
    endgenerate

    assign match = shift & (fill_reg >= FILL_ARM) & (&bit_eq);

    always_comb begin
        history_next = history_reg;
        fill_next    = fill_reg;
        if (clr) begin
            history_next = '0;
            fill_next    = '0;
        end else if (shift) begin
            history_next = candidate[PAT_W-2:0];
            if (!match) begin
                fill_next = (fill_reg == FILL_MAX) ? fill_reg : fill_reg + FILL_W'(1);
            end else if (!overlap) begin
                // Non-overlapping: the next match must be built from fresh bits only.
                fill_next = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            history_reg <= '0;
            fill_reg    <= '0;
        end else begin
            history_reg <= history_next;
            fill_reg    <= fill_next;
        end
    end

endmodule

// File: rtl/seq_frame_det_ctrl.sv
// Frame controller: latches config on start, accepts frame_len bits, counts
// matches with saturation and pulses done one cycle after the last bit.
module seq_frame_det_ctrl
    import seq_det_pkg::*;
#(
    parameter int PAT_W = 4,
    parameter int LEN_W = 8,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [PAT_W-1:0]     cfg_pattern,
    input  logic                 cfg_overlap,
    input  logic [LEN_W-1:0]     frame_len,
    seq_frame_det_ctrl_if.slave  bit_if,
    output logic                 match,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     match_cnt,
    output logic                 overflow
);
    state_t            state_reg, state_next;
    logic [LEN_W-1:0]  remaining_reg, remaining_next;
    logic [PAT_W-1:0]  pattern_reg, pattern_next;
    logic              overlap_reg, overlap_next;
    logic [CNT_W-1:0]  match_cnt_reg, match_cnt_next;
    logic              overflow_reg, overflow_next;

    logic start_ok;
    logic frame_go;
    logic accepted;
    logic shift;

    assign start_ok = (state_reg == IDLE) & start;
    assign frame_go = start_ok & (frame_len != '0);
    assign accepted = bit_if.bit_valid & bit_if.bit_ready;
    // A bit accepted alongside abort is dropped entirely.
    assign shift    = accepted & ~abort;

    assign bit_if.bit_ready = (state_reg == RUN);
    assign busy             = (state_reg == RUN);
    assign done             = (state_reg == DONE);
    assign match_cnt        = match_cnt_reg;
    assign overflow         = overflow_reg;

    seq_match_core #(
        .PAT_W (PAT_W)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .clr     (frame_go),
        .shift   (shift),
        .bit_in  (bit_if.bit_in),
        .pattern (pattern_reg),
        .overlap (overlap_reg),
        .match   (match)
    );

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = (frame_len != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (shift && (remaining_reg == LEN_W'(1))) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        remaining_next = remaining_reg;
        pattern_next   = pattern_reg;
        overlap_next   = overlap_reg;
        if (frame_go) begin
            remaining_next = frame_len;
            pattern_next   = cfg_pattern;
            overlap_next   = cfg_overlap;
        end else if (shift) begin
            remaining_next = remaining_reg - LEN_W'(1);
        end
    end

    always_comb begin
        match_cnt_next = match_cnt_reg;
        overflow_next  = overflow_reg;
        if (start_ok) begin
            match_cnt_next = '0;
            overflow_next  = 1'b0;
        end else if (match) begin
            // Saturate: a match that cannot be counted flags overflow instead.
            if (&match_cnt_reg) begin
                overflow_next = 1'b1;
            end else begin
                match_cnt_next = match_cnt_reg + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            remaining_reg <= '0;
            pattern_reg   <= '0;
            overlap_reg   <= 1'b0;
            match_cnt_reg <= '0;
            overflow_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            remaining_reg <= remaining_next;
            pattern_reg   <= pattern_next;
            overlap_reg   <= overlap_next;
            match_cnt_reg <= match_cnt_next;
            overflow_reg  <= overflow_next;
        end
    end

endmodule

// File: tb/tb_seq_frame_det_ctrl.sv
// Directed bench: vector table for whole frames plus hand sequences for
// saturation, abort, zero-length frames and asynchronous reset.
module tb_seq_frame_det_ctrl;
    import seq_det_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // DUT A: default parameters
    logic       a_start, a_abort, a_ovl;
    logic [3:0] a_pat;
    logic [7:0] a_len;
    logic       a_match, a_busy, a_done, a_ovf;
    logic [7:0] a_cnt;
    seq_frame_det_ctrl_if a_if();

    seq_frame_det_ctrl #(.PAT_W(4), .LEN_W(8), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .start(a_start), .abort(a_abort),
        .cfg_pattern(a_pat), .cfg_overlap(a_ovl), .frame_len(a_len),
        .bit_if(a_if), .match(a_match), .busy(a_busy), .done(a_done),
        .match_cnt(a_cnt), .overflow(a_ovf)
    );

    // DUT B: 2-bit pattern, 2-bit counter for saturation
    logic       b_start, b_abort, b_ovl;
    logic [1:0] b_pat;
    logic [7:0] b_len;
    logic       b_match, b_busy, b_done, b_ovf;
    logic [1:0] b_cnt;
    seq_frame_det_ctrl_if b_if();

    seq_frame_det_ctrl #(.PAT_W(2), .LEN_W(8), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .abort(b_abort),
        .cfg_pattern(b_pat), .cfg_overlap(b_ovl), .frame_len(b_len),
        .bit_if(b_if), .match(b_match), .busy(b_busy), .done(b_done),
        .match_cnt(b_cnt), .overflow(b_ovf)
    );

    typedef struct {
        logic       start, abort, valid, din;
        logic [3:0] pat;
        logic       ovl;
        logic [7:0] len;
        logic       ready, match, busy, done;
        logic [7:0] cnt;
        logic       ovf;
    } vec_t;

    vec_t vq[$];
    int   errors = 0;
    int   checks = 0;

    localparam logic [9:0] STREAM  = 10'b1001001001;
    localparam logic [9:0] MASK_NO = 10'b0001000001;  // bits 4 and 10
    localparam logic [9:0] MASK_OV = 10'b0001001001;  // bits 4, 7 and 10

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // ctl = {start, abort, valid, din}; exp = {ready, match, busy, done}
    task automatic push(input logic [3:0] ctl, input logic [3:0] p, input logic o,
                        input logic [7:0] l, input logic [3:0] exp, input logic [7:0] c);
        vec_t x;
        x.start = ctl[3]; x.abort = ctl[2]; x.valid = ctl[1]; x.din = ctl[0];
        x.pat   = p;      x.ovl   = o;      x.len   = l;
        x.ready = exp[3]; x.match = exp[2]; x.busy  = exp[1]; x.done = exp[0];
        x.cnt   = c;      x.ovf   = 1'b0;
        vq.push_back(x);
    endtask

    // Start cycle, len bit cycles (valid every cycle), then the DONE cycle.
    // During RUN the cfg inputs carry junk that must be ignored.
    task automatic build_frame(input logic [9:0] stream, input int len, input logic [9:0] mmask,
                               input logic [3:0] p, input logic o, input logic [7:0] cnt0);
        logic [7:0] c;
        logic       bv, mv;
        c = 8'd0;
        push(4'b1000, p, o, 8'(len), 4'b0000, cnt0);
        for (int i = 0; i < len; i++) begin
            bv = stream[len-1-i];
            mv = mmask[len-1-i];
            push({3'b001, bv}, 4'b0110, ~o, 8'd3, {1'b1, mv, 2'b10}, c);
            if (mv) c = c + 8'd1;
        end
        push(4'b0000, p, o, 8'(len), 4'b0001, c);
    endtask

    task automatic run_vectors(input string tag);
        vec_t v;
        for (int i = 0; i < vq.size(); i++) begin
            v = vq[i];
            a_start = v.start; a_abort = v.abort;
            a_if.bit_valid = v.valid; a_if.bit_in = v.din;
            a_pat = v.pat; a_ovl = v.ovl; a_len = v.len;
            #4;
            chk($sformatf("%s[%0d].ready", tag, i), 32'(a_if.bit_ready), 32'(v.ready));
            chk($sformatf("%s[%0d].match", tag, i), 32'(a_match), 32'(v.match));
            chk($sformatf("%s[%0d].busy",  tag, i), 32'(a_busy),  32'(v.busy));
            chk($sformatf("%s[%0d].done",  tag, i), 32'(a_done),  32'(v.done));
            chk($sformatf("%s[%0d].cnt",   tag, i), 32'(a_cnt),   32'(v.cnt));
            chk($sformatf("%s[%0d].ovf",   tag, i), 32'(a_ovf),   32'(v.ovf));
            $display("%s[%0d] start=%0b abort=%0b valid=%0b bit=%0b -> ready=%0b match=%0b busy=%0b done=%0b cnt=%0d",
                     tag, i, v.start, v.abort, v.valid, v.din,
                     a_if.bit_ready, a_match, a_busy, a_done, a_cnt);
            cyc();
        end
        a_start = 1'b0; a_abort = 1'b0; a_if.bit_valid = 1'b0; a_if.bit_in = 1'b0;
    endtask

    task automatic a_bit(input logic d, input logic exp_m, input string name);
        a_if.bit_valid = 1'b1; a_if.bit_in = d;
        #4;
        chk(name, 32'(a_match), 32'(exp_m));
        $display("%s bit=%0b match=%0b cnt=%0d", name, d, a_match, a_cnt);
        cyc();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        a_start = 1'b0; a_abort = 1'b0; a_pat = 4'b0; a_ovl = 1'b0; a_len = 8'd0;
        a_if.bit_valid = 1'b0; a_if.bit_in = 1'b0;
        b_start = 1'b0; b_abort = 1'b0; b_pat = 2'b0; b_ovl = 1'b0; b_len = 8'd0;
        b_if.bit_valid = 1'b0; b_if.bit_in = 1'b0;
        #3;
        chk("reset.a_ready", 32'(a_if.bit_ready), 32'd0);
        chk("reset.a_busy",  32'(a_busy), 32'd0);
        chk("reset.a_done",  32'(a_done), 32'd0);
        chk("reset.a_cnt",   32'(a_cnt),  32'd0);
        chk("reset.a_ovf",   32'(a_ovf),  32'd0);
        chk("reset.b_busy",  32'(b_busy), 32'd0);
        chk("reset.b_cnt",   32'(b_cnt),  32'd0);
        @(posedge clk);
        cyc();
        rst = 1'b0;

        // Frame 1 (non-overlap), frame 2 (overlap) back-to-back, then toggling valid
        build_frame(STREAM, 10, MASK_NO, PAT_1001, 1'b0, 8'd0);
        build_frame(STREAM, 10, MASK_OV, PAT_1001, 1'b1, 8'd2);
        push(4'b0000, 4'b0, 1'b0, 8'd0, 4'b0000, 8'd3);
        push(4'b1000, PAT_1001, 1'b0, 8'd6, 4'b0000, 8'd3);
        // accepted bits 1,0,0,1,0,0 on odd cycles; idle cycles carry junk 1s
        push(4'b0011, 4'b0, 1'b0, 8'd0, 4'b1010, 8'd0);
        push(4'b0001, 4'b0, 1'b0, 8'd0, 4'b1010, 8'd0);
        push(4'b0010, 4'b0, 1'b0, 8'd0, 4'b1010, 8'd0);
        push(4'b0001, 4'b0, 1'b0, 8'd0, 4'b1010, 8'd0);
        push(4'b0010, 4'b0, 1'b0, 8'd0, 4'b1010, 8'd0);
        push(4'b0001, 4'b0, 1'b0, 8'd0, 4'b1010, 8'd0);
        push(4'b0011, 4'b0, 1'b0, 8'd0, 4'b1110, 8'd0);
        push(4'b0001, 4'b0, 1'b0, 8'd0, 4'b1010, 8'd1);
        push(4'b0010, 4'b0, 1'b0, 8'd0, 4'b1010, 8'd1);
        push(4'b0001, 4'b0, 1'b0, 8'd0, 4'b1010, 8'd1);
        push(4'b0010, 4'b0, 1'b0, 8'd0, 4'b1010, 8'd1);
        // DONE with start asserted: must be ignored
        push(4'b1000, PAT_1001, 1'b0, 8'd6, 4'b0001, 8'd1);
        push(4'b0000, 4'b0, 1'b0, 8'd0, 4'b0000, 8'd1);
        run_vectors("tbl");

        // Saturation on DUT B: pattern 11, overlap, 8 ones -> 7 matches
        b_pat = 2'b11; b_ovl = 1'b1; b_len = 8'd8; b_start = 1'b1;
        cyc();
        b_start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            b_if.bit_valid = 1'b1; b_if.bit_in = 1'b1;
            #4;
            chk($sformatf("sat.bit%0d.match", i + 1), 32'(b_match), (i >= 1) ? 32'd1 : 32'd0);
            $display("sat bit%0d match=%0b cnt=%0d ovf=%0b", i + 1, b_match, b_cnt, b_ovf);
            cyc();
        end
        b_if.bit_valid = 1'b0;
        #4;
        chk("sat.done", 32'(b_done), 32'd1);
        chk("sat.cnt",  32'(b_cnt),  32'd3);
        chk("sat.ovf",  32'(b_ovf),  32'd1);
        cyc();
        #4;
        chk("sat.idle_ovf", 32'(b_ovf), 32'd1);
        chk("sat.idle_cnt", 32'(b_cnt), 32'd3);
        cyc();
        b_len = 8'd0; b_start = 1'b1;
        #4;
        chk("sat.pre_start_ovf", 32'(b_ovf), 32'd1);
        cyc();
        b_start = 1'b0;
        #4;
        chk("sat.zero_done", 32'(b_done), 32'd1);
        chk("sat.zero_ovf",  32'(b_ovf),  32'd0);
        chk("sat.zero_cnt",  32'(b_cnt),  32'd0);
        cyc();

        // Abort after 5 bits, then a zero-length frame
        a_pat = PAT_1001; a_ovl = 1'b0; a_len = 8'd10; a_start = 1'b1;
        cyc();
        a_start = 1'b0;
        a_bit(1'b1, 1'b0, "abort.b1");
        a_bit(1'b0, 1'b0, "abort.b2");
        a_bit(1'b0, 1'b0, "abort.b3");
        a_bit(1'b1, 1'b1, "abort.b4");
        a_bit(1'b0, 1'b0, "abort.b5");
        a_abort = 1'b1; a_if.bit_valid = 1'b1; a_if.bit_in = 1'b1;
        #4;
        chk("abort.same_cycle_match", 32'(a_match), 32'd0);
        cyc();
        a_abort = 1'b0; a_if.bit_valid = 1'b0;
        #4;
        chk("abort.busy",  32'(a_busy), 32'd0);
        chk("abort.ready", 32'(a_if.bit_ready), 32'd0);
        chk("abort.done",  32'(a_done), 32'd0);
        chk("abort.cnt",   32'(a_cnt),  32'd1);
        cyc();
        #4;
        chk("abort.done_later", 32'(a_done), 32'd0);
        a_len = 8'd0; a_start = 1'b1;
        cyc();
        a_start = 1'b0;
        #4;
        chk("zero.done", 32'(a_done), 32'd1);
        chk("zero.busy", 32'(a_busy), 32'd0);
        chk("zero.cnt",  32'(a_cnt),  32'd0);
        chk("zero.ovf",  32'(a_ovf),  32'd0);
        cyc();
        #4;
        chk("zero.done_end", 32'(a_done), 32'd0);
        cyc();

        // Asynchronous reset in the middle of a frame
        a_pat = PAT_1001; a_ovl = 1'b0; a_len = 8'd10; a_start = 1'b1;
        cyc();
        a_start = 1'b0;
        a_bit(1'b1, 1'b0, "rst.b1");
        a_bit(1'b0, 1'b0, "rst.b2");
        a_bit(1'b0, 1'b0, "rst.b3");
        a_bit(1'b1, 1'b1, "rst.b4");
        a_bit(1'b1, 1'b0, "rst.b5");
        a_bit(1'b0, 1'b0, "rst.b6");
        a_bit(1'b0, 1'b0, "rst.b7");
        a_if.bit_valid = 1'b1; a_if.bit_in = 1'b1;
        #1;
        chk("rst.pre_cnt",  32'(a_cnt),  32'd1);
        chk("rst.pre_busy", 32'(a_busy), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("rst.ready", 32'(a_if.bit_ready), 32'd0);
        chk("rst.busy",  32'(a_busy),  32'd0);
        chk("rst.match", 32'(a_match), 32'd0);
        chk("rst.cnt",   32'(a_cnt),   32'd0);
        chk("rst.ovf",   32'(a_ovf),   32'd0);
        a_if.bit_valid = 1'b0; a_if.bit_in = 1'b0;
        cyc();
        rst = 1'b0;
        cyc();
        vq.delete();
        build_frame(STREAM, 10, MASK_NO, PAT_1001, 1'b0, 8'd0);
        run_vectors("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
